// File: rtl/nn_pkg.sv
// Shared definitions for the NN parameter memory: writer FSM encoding, parameter
// indices and the address map defaults also used by the NN core.
package nn_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StCheck = 2'd2,
        StError = 2'd3
    } state_e;

    // Positions of the shift/bias words within the 10-word parameter frame
    localparam int unsigned SHIFT_BIAS_1 = 7;
    localparam int unsigned SHIFT_BIAS_2 = 8;
    localparam int unsigned SHIFT_BIAS_3 = 9;

    localparam int unsigned DEF_BASE_ADDR   = 8;
    localparam int unsigned DEF_PAIR_STRIDE = 8;
    localparam int unsigned DEF_PAIR_OFFSET = 4;

endpackage

// File: rtl/nn_param_addr_gen.sv
// Combinational parameter index -> memory address map (pairs of words per row).
module nn_param_addr_gen
    import nn_pkg::*;
#(
    parameter int unsigned ADDRW       = 8,
    parameter int unsigned IDXW        = 4,
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned PAIR_STRIDE = DEF_PAIR_STRIDE,
    parameter int unsigned PAIR_OFFSET = DEF_PAIR_OFFSET
) (
    input  logic [IDXW-1:0]  idx,
    output logic [ADDRW-1:0] addr
);

    logic [ADDRW-1:0] pair;
    logic [ADDRW-1:0] odd_off;

    // All arithmetic stays in ADDRW bits so out-of-range maps wrap
    always_comb begin
        pair    = ADDRW'(idx >> 1);
        odd_off = idx[0] ? ADDRW'(PAIR_OFFSET) : '0;
        addr    = ADDRW'(BASE_ADDR) + pair * ADDRW'(PAIR_STRIDE) + odd_off;
    end

endmodule

// File: rtl/nn_param_writer.sv
// Writes one checksummed parameter frame from a valid/ready stream into the
// NN parameter RAM and flags the set valid only after a clean frame.
module nn_param_writer
    import nn_pkg::*;
#(
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned ADDRW       = 8,
    parameter int unsigned NUM_WORDS   = 10,
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned PAIR_STRIDE = DEF_PAIR_STRIDE,
    parameter int unsigned PAIR_OFFSET = DEF_PAIR_OFFSET
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDRW-1:0]     mem_addr,
    output logic [DATAWIDTH-1:0] mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 params_valid,
    output logic                 err_len,
    output logic                 err_csum,
    output logic [3:0]           word_count
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] acc_q, acc_d;
    logic [3:0]           wc_q, wc_d;
    logic                 we_q, we_d;
    logic [ADDRW-1:0]     addr_q, addr_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic                 done_q, done_d;
    logic                 pv_q, pv_d;
    logic                 el_q, el_d;
    logic                 ec_q, ec_d;
    logic [ADDRW-1:0]     beat_addr;
    logic                 beat;

    nn_param_addr_gen #(
        .ADDRW       (ADDRW),
        .IDXW        (4),
        .BASE_ADDR   (BASE_ADDR),
        .PAIR_STRIDE (PAIR_STRIDE),
        .PAIR_OFFSET (PAIR_OFFSET)
    ) u_addr_gen (
        .idx  (wc_q),
        .addr (beat_addr)
    );

    always_comb begin
        in_ready = (state_q == StLoad) || (state_q == StCheck);
        busy     = in_ready;
        // A start in the same cycle aborts the frame, so its beat is dropped
        beat     = in_valid && in_ready && !start;

        state_d = state_q;
        acc_d   = acc_q;
        wc_d    = wc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        pv_d    = pv_q;
        el_d    = el_q;
        ec_d    = ec_q;

        if (start) begin
            state_d = StLoad;
            acc_d   = '0;
            wc_d    = '0;
            pv_d    = 1'b0;
            el_d    = 1'b0;
            ec_d    = 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (beat) begin
                        if (in_last) begin
                            el_d    = 1'b1;
                            state_d = StError;
                        end else begin
                            we_d    = 1'b1;
                            addr_d  = beat_addr;
                            wdata_d = in_data;
                            acc_d   = acc_q ^ in_data;
                            wc_d    = wc_q + 4'd1;
                            if (wc_q == LAST_IDX) state_d = StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (beat) begin
                        if (!in_last) begin
                            el_d    = 1'b1;
                            state_d = StError;
                        end else if (in_data != acc_q) begin
                            ec_d    = 1'b1;
                            state_d = StError;
                        end else begin
                            done_d  = 1'b1;
                            pv_d    = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            acc_q   <= '0;
            wc_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            pv_q    <= 1'b0;
            el_q    <= 1'b0;
            ec_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wc_q    <= wc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            pv_q    <= pv_d;
            el_q    <= el_d;
            ec_q    <= ec_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign done         = done_q;
    assign params_valid = pv_q;
    assign err_len      = el_q;
    assign err_csum     = ec_q;
    assign word_count   = wc_q;

endmodule
